// File: rtl/cheby_dpssram_arb_pkg.sv
// Shared types for the two-requester single-port SRAM arbiter: FSM state
// encoding and requester index constants.
package cheby_dpssram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_ACK    = 2'd3
  } arb_state_e;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage : cheby_dpssram_arb_pkg

// File: rtl/cheby_dpssram_arb_rr.sv
// Two-way round-robin arbiter: picks a grant index from req[1:0], and
// remembers the last winner only when the caller strobes update_i.
module cheby_rr_arb2
  import cheby_dpssram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       update_i,
  output logic       gnt_o
);

  logic last_q;
  logic last_d;

  // On a tie (or no request) the side that did not win last time is offered.
  always_comb begin
    gnt_o = (last_q == REQ_A) ? REQ_B : REQ_A;
    case (req_i)
      2'b01:   gnt_o = REQ_A;
      2'b10:   gnt_o = REQ_B;
      default: gnt_o = (last_q == REQ_A) ? REQ_B : REQ_A;
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (update_i) begin
      last_d = gnt_o;
    end
  end

  // Reset pretends B won last so that A takes the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= REQ_B;
    end else begin
      last_q <= last_d;
    end
  end

endmodule : cheby_rr_arb2

// File: rtl/cheby_dpssram_arb.sv
// Arbitrates two request/ack masters onto one SRAM port. Each access takes
// four cycles: IDLE (grant/latch), ACCESS (strobe), WAIT (capture), ACK.
module cheby_dpssram_arb
  import cheby_dpssram_arb_pkg::*;
#(
  parameter int g_addr_width = 10,
  parameter int g_data_width = 8,
  parameter int g_sel_width  = g_data_width / 8
) (
  input  logic                    aclk,
  input  logic                    areset,

  input  logic                    a_req_i,
  input  logic                    a_we_i,
  input  logic [g_addr_width-1:0] a_adr_i,
  input  logic [g_data_width-1:0] a_dat_i,
  input  logic [g_sel_width-1:0]  a_sel_i,
  output logic                    a_ack_o,
  output logic [g_data_width-1:0] a_dat_o,

  input  logic                    b_req_i,
  input  logic                    b_we_i,
  input  logic [g_addr_width-1:0] b_adr_i,
  input  logic [g_data_width-1:0] b_dat_i,
  input  logic [g_sel_width-1:0]  b_sel_i,
  output logic                    b_ack_o,
  output logic [g_data_width-1:0] b_dat_o,

  output logic [g_addr_width-1:0] ram_adr_o,
  output logic [g_sel_width-1:0]  ram_sel_o,
  output logic [g_data_width-1:0] ram_dat_o,
  output logic                    ram_rd_o,
  output logic                    ram_wr_o,
  input  logic [g_data_width-1:0] ram_dat_i,

  output logic                    busy_o
);

  arb_state_e              state_q,  state_d;
  logic                    we_q,     we_d;
  logic [g_addr_width-1:0] adr_q,    adr_d;
  logic [g_data_width-1:0] dat_q,    dat_d;
  logic [g_sel_width-1:0]  sel_q,    sel_d;
  logic                    gnt_q,    gnt_d;
  logic [g_data_width-1:0] rdata_q,  rdata_d;
  logic [g_data_width-1:0] a_hold_q, a_hold_d;
  logic [g_data_width-1:0] b_hold_q, b_hold_d;

  logic arb_gnt;
  logic arb_update;

  cheby_rr_arb2 u_rr_arb (
    .clk      (aclk),
    .rst      (areset),
    .req_i    ({b_req_i, a_req_i}),
    .update_i (arb_update),
    .gnt_o    (arb_gnt)
  );

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    sel_d      = sel_q;
    gnt_d      = gnt_q;
    rdata_d    = rdata_q;
    a_hold_d   = a_hold_q;
    b_hold_d   = b_hold_q;
    arb_update = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (a_req_i || b_req_i) begin
          arb_update = 1'b1;
          gnt_d      = arb_gnt;
          if (arb_gnt == REQ_B) begin
            we_d  = b_we_i;
            adr_d = b_adr_i;
            dat_d = b_dat_i;
            sel_d = b_sel_i;
          end else begin
            we_d  = a_we_i;
            adr_d = a_adr_i;
            dat_d = a_dat_i;
            sel_d = a_sel_i;
          end
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (!we_q) begin
          rdata_d = ram_dat_i;
        end
        state_d = ST_ACK;
      end
      ST_ACK: begin
        // The granted side keeps what it was shown once its ack drops.
        if (gnt_q == REQ_A) begin
          a_hold_d = rdata_q;
        end else begin
          b_hold_d = rdata_q;
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    ram_adr_o = adr_q;
    ram_sel_o = sel_q;
    ram_dat_o = dat_q;
    ram_rd_o  = (state_q == ST_ACCESS) && !we_q;
    ram_wr_o  = (state_q == ST_ACCESS) &&  we_q;
    a_ack_o   = (state_q == ST_ACK) && (gnt_q == REQ_A);
    b_ack_o   = (state_q == ST_ACK) && (gnt_q == REQ_B);
    a_dat_o   = a_ack_o ? rdata_q : a_hold_q;
    b_dat_o   = b_ack_o ? rdata_q : b_hold_q;
    busy_o    = (state_q != ST_IDLE);
  end

  // Latched request fields are cleared too, so the RAM-facing bus reads zero in reset.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q  <= ST_IDLE;
      we_q     <= 1'b0;
      adr_q    <= '0;
      dat_q    <= '0;
      sel_q    <= '0;
      gnt_q    <= REQ_A;
      rdata_q  <= '0;
      a_hold_q <= '0;
      b_hold_q <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      sel_q    <= sel_d;
      gnt_q    <= gnt_d;
      rdata_q  <= rdata_d;
      a_hold_q <= a_hold_d;
      b_hold_q <= b_hold_d;
    end
  end

endmodule : cheby_dpssram_arb

// File: doc/cheby_dpssram_arb.md
CHEBY_DPSSRAM_ARB -- requirements
Module: cheby_dpssram_arb

Interface
REQ-001 SHALL have parameter g_addr_width, default 10, the RAM word-address width.
REQ-002 SHALL have parameter g_data_width, default 8, the RAM data width (multiple of 8).
REQ-003 SHALL have parameter g_sel_width, default g_data_width/8, the byte-select width.
REQ-004 SHALL have port aclk  in  1  single clock; all logic rising-edge.
REQ-005 SHALL have port areset  in  1  reset, synchronous, active-high.
REQ-006 SHALL have ports a_req_i / b_req_i  in  1  access request, held until ack.
REQ-007 SHALL have ports a_we_i / b_we_i  in  1  1 = write, 0 = read.
REQ-008 SHALL have ports a_adr_i / b_adr_i  in  g_addr_width  word address.
REQ-009 SHALL have ports a_dat_i / b_dat_i  in  g_data_width  write data.
REQ-010 SHALL have ports a_sel_i / b_sel_i  in  g_sel_width  byte select for writes.
REQ-011 SHALL have ports a_ack_o / b_ack_o  out  1  one-cycle completion pulse.
REQ-012 SHALL have ports a_dat_o / b_dat_o  out  g_data_width  read data, valid while the matching ack is high.
REQ-013 SHALL have ports ram_adr_o (g_addr_width), ram_sel_o (g_sel_width), ram_dat_o (g_data_width), ram_rd_o (1) and ram_wr_o (1), all outputs, driving one cheby_dpssram port.
REQ-014 SHALL have port ram_dat_i  in  g_data_width  RAM read data, valid one cycle after ram_rd_o.
REQ-015 SHALL have port busy_o  out  1  high whenever the state is not IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, ACCESS, WAIT and ACK.
REQ-017 IDLE: if any req is high, SHALL select a requester, register its we/adr/dat/sel and the grant index, and go to ACCESS; otherwise SHALL stay in IDLE.
REQ-018 Arbitration: single request SHALL win; with both requests high, the requester not granted last SHALL win; after reset, A SHALL win the first tie.
REQ-019 ACCESS: ram_adr_o, ram_sel_o and ram_dat_o SHALL carry the latched values, and exactly one of ram_wr_o / ram_rd_o SHALL be high for exactly this one cycle; next state WAIT.
REQ-020 WAIT: for a read, SHALL register ram_dat_i into the read-data register; for a write, SHALL leave that register unchanged; next state ACK.
REQ-021 ACK: SHALL pulse only the granted requester's ack_o for one cycle and present the read-data register on its dat_o; next state IDLE.
REQ-022 Latency: req sampled in IDLE at cycle 0 SHALL produce ack at cycle 3; the maximum rate SHALL be one access per 4 cycles.
REQ-023 ram_rd_o and ram_wr_o SHALL be 0 in every state other than ACCESS.
REQ-024 Non-granted dat_o SHALL hold its last value; ram_sel_o SHALL be passed through unchanged for reads, and the RAM ignores it.
REQ-025 A req deasserted after grant SHALL NOT abort the access: the access and its ack SHALL complete.
REQ-026 A req still high in the cycle after ack SHALL be treated as a new request in IDLE.
REQ-027 The round-robin pointer SHALL update only on entry to ACCESS.

Reset
REQ-028 While areset is high, the FSM SHALL go to IDLE, round-robin SHALL favour A, and all acks, ram_rd_o, ram_wr_o and busy_o SHALL be 0.
REQ-029 While areset is high, ram_adr_o, ram_sel_o, ram_dat_o and both dat_o SHALL be 0.
REQ-030 Reset asserted mid-access SHALL drop all strobes and acks at the next edge, and the pending access SHALL be discarded with no ack.

Structure
REQ-031 A shared package SHALL hold the FSM state enum and the requester-index constants (REQ_A = 0, REQ_B = 1).
REQ-032 Arbitration SHALL be placed in one sub-module, cheby_rr_arb2 (2-way round-robin: req[1:0], update strobe, grant index), and the FSM and datapath SHALL stay in cheby_dpssram_arb.

Verification
REQ-033 A writes adr 0x3FF, dat 0xA5, sel 1 -> ram_wr_o high exactly at cycle 1 with adr 0x3FF; a_ack_o pulses at cycle 3; b_ack_o stays 0.
REQ-034 Following REQ-033, A reads adr 0x3FF with a RAM model of latency 1 -> a_dat_o = 0xA5 while a_ack_o is high.
REQ-035 A and B both request continuously from reset -> grants A, B, A, B; acks at cycles 3, 7, 11, 15.
REQ-036 A requests, then drops req at cycle 1 -> access completes and a_ack_o still pulses at cycle 3.
REQ-037 areset asserted at cycle 1 of a write -> ram_wr_o = 0 and busy_o = 0 the next cycle, with no ack; the next tie after reset grants A.
REQ-038 B reads with ram_dat_i = 0x5A -> b_dat_o = 0x5A at ack, and a_dat_o is unchanged.
